// File: rtl/seven_segment_arbiter_pkg.sv
// Shared encodings, widths and display-word type for the seven-segment arbiter.
package seven_segment_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   localparam int DIGITS   = 8;
   localparam int NIBBLE_W = 4;
   localparam int DIGIT_W  = DIGITS * NIBBLE_W;

   localparam logic [DIGITS-1:0] BLANK_EN = 8'h00;

   typedef struct packed {
      logic [DIGIT_W-1:0] digit;
      logic [DIGITS-1:0]  dot;
      logic [DIGITS-1:0]  en;
   } disp_t;

   // Round-robin successor of a requester index, wrapping at n-1.
   function automatic logic [2:0] ptr_inc(input logic [2:0] idx, input int n);
      return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/seven_segment_arbiter_if.sv
// Requester-side bus plus the registered controller drive of the arbiter.
interface seven_segment_arbiter_if import seven_segment_pkg::*; #(
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]         req;
   logic [NREQ*DIGIT_W-1:0] req_digit;
   logic [NREQ*DIGITS-1:0]  req_dot;
   logic [NREQ*DIGITS-1:0]  req_en;
   logic [NREQ-1:0]         grant;
   logic [2:0]              owner;
   logic [DIGIT_W-1:0]      digit;
   logic [DIGITS-1:0]       en_dot;
   logic [DIGITS-1:0]       en_digit;

   modport master (output req, req_digit, req_dot, req_en,
                   input  grant, owner, digit, en_dot, en_digit);
   modport slave  (input  req, req_digit, req_dot, req_en,
                   output grant, owner, digit, en_dot, en_digit);
endinterface

// File: rtl/seven_segment_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_picker import seven_segment_pkg::*; #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [2:0]      i_ptr,
   output logic            o_valid,
   output logic [2:0]      o_idx
);
   logic [NREQ-1:0] w_rot;
   logic [3:0]      w_off;
   logic [3:0]      w_sum;

   always_comb begin
      // Rotate so bit 0 is the pointer position; lowest set bit wins.
      w_rot   = NREQ'({i_req, i_req} >> i_ptr);
      o_valid = 1'b0;
      w_off   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_valid = 1'b1;
            w_off   = 4'(k);
         end
      end
      w_sum = 4'(i_ptr) + w_off;
      o_idx = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : 3'(w_sum);
   end
endmodule

// File: rtl/seven_segment_arbiter.sv
// Time-shares one 8-digit seven-segment controller between NREQ requesters:
// round-robin grants, minimum dwell per grant, blank gap between owners.
module seven_segment_arbiter import seven_segment_pkg::*; #(
   parameter int NREQ         = 4,
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int BLANK_CYCLES = 1_000_000,
   parameter int CNT_W        = 32
) (
   input logic                    i_clk,
   input logic                    i_rst,
   seven_segment_arbiter_if.slave io_bus
);
   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

   logic [1:0]       r_state;
   logic [2:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [NREQ-1:0]  r_grant;
   logic [2:0]       r_owner;
   disp_t            r_disp;

   logic             w_valid;
   logic [2:0]       w_idx;
   disp_t            w_sel;
   logic             w_own_req;
   logic             w_other_req;

   rr_picker #(.NREQ(NREQ)) u_pick (
      .i_req   (io_bus.req),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   // grant is one-hot while showing, so an AND-OR mux selects the owner.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant[i]) begin
            w_sel.digit = w_sel.digit | io_bus.req_digit[DIGIT_W*i +: DIGIT_W];
            w_sel.dot   = w_sel.dot   | io_bus.req_dot[DIGITS*i +: DIGITS];
            w_sel.en    = w_sel.en    | io_bus.req_en[DIGITS*i +: DIGITS];
         end
      end
   end

   assign w_own_req   = |(io_bus.req & r_grant);
   assign w_other_req = |(io_bus.req & ~r_grant);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_grant <= '0;
         r_owner <= '0;
         r_disp  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_disp.dot <= BLANK_EN;
               r_disp.en  <= BLANK_EN;
               if (w_valid) begin
                  r_grant <= ONE_HOT0 << w_idx;
                  r_owner <= w_idx;
                  r_ptr   <= ptr_inc(w_idx, NREQ);
                  r_cnt   <= DWELL_LD;
                  r_state <= ST_SHOW;
               end
            end
            ST_SHOW: begin
               // Owner release wins over expiry; expiry only yields if someone waits.
               if (!w_own_req || (r_cnt == '0 && w_other_req)) begin
                  r_grant    <= '0;
                  r_disp.dot <= BLANK_EN;
                  r_disp.en  <= BLANK_EN;
                  r_cnt      <= BLANK_LD;
                  r_state    <= ST_BLANK;
               end else begin
                  r_disp <= w_sel;
                  r_cnt  <= (r_cnt == '0) ? DWELL_LD : r_cnt - 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_cnt == '0) r_state <= ST_IDLE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_bus.grant    = r_grant;
   assign io_bus.owner    = r_owner;
   assign io_bus.digit    = r_disp.digit;
   assign io_bus.en_dot   = r_disp.dot;
   assign io_bus.en_digit = r_disp.en;

endmodule
